// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule. It accepts one padded 512-bit block, expands it
// into W[0..NUM_ROUNDS-1] using a 16-word sliding window, and issues one
// {W, K} pair per round to the downstream round datapath.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   blk_valid/ready   block handshake; blk_data word 0 is in [511:480]
//   advance           downstream consumes the current round (0 = stall)
//   round_valid       W/K/round_idx describe round round_idx
//   round_idx, W, K   current round, message word, round constant
//   init, done        round_valid qualified strobes for t==0 and t==NUM_ROUNDS-1
//
// Optional feature: define SHA_SCHED_PREFETCH_EN to accept the next block on
// the last advance edge, giving back-to-back blocks with no idle cycle.
module sha256_msg_schedule #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         advance,
  output logic         round_valid,
  output logic [5:0]   round_idx,
  output logic [31:0]  W,
  output logic [31:0]  K,
  output logic         init,
  output logic         done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] win [16];
  logic        last_adv;
  logic        accept;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign last_adv = (state == RUN) && (round_idx == LAST_IDX) && advance;

`ifdef SHA_SCHED_PREFETCH_EN
  // Last advance edge doubles as a load slot for the next block.
  assign blk_ready = (state == IDLE) || last_adv;
`else
  assign blk_ready = (state == IDLE);
`endif

  assign accept = blk_valid && blk_ready;
  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // Outputs are direct decodes of registered state.
  assign round_valid = (state == RUN);
  assign W           = win[0];
  assign init        = round_valid && (round_idx == 6'd0);
  assign done        = round_valid && (round_idx == LAST_IDX);

  // Control FSM, window and K register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_idx <= 6'd0;
      K         <= 32'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) win[i] <= blk_data[32*(15-i) +: 32];
      round_idx <= 6'd0;
      K         <= K_ROM[0];
      state     <= RUN;
    end else if ((state == RUN) && advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
      if (last_adv) begin
        state     <= IDLE;
        round_idx <= 6'd0;
      end else begin
        round_idx <= round_idx + 6'd1;
        K         <= K_ROM[round_idx + 6'd1];
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: two instances (64 and 20 rounds), a
// transaction-level model with the full FIPS W[0..63] expansion and K
// constants derived from cube roots of primes, and a per-cycle compare.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst_i   [2];
  logic         bv_i    [2];
  logic [511:0] bd_i    [2];
  logic         adv_i   [2];
  logic         br_o    [2];
  logic         rv_o    [2];
  logic [5:0]   idx_o   [2];
  logic [31:0]  w_o     [2];
  logic [31:0]  k_o     [2];
  logic         init_o  [2];
  logic         done_o  [2];

  int checks = 0;
  int errors = 0;

  sha256_msg_schedule dut0 (
    .clk(clk), .rst(rst_i[0]), .blk_valid(bv_i[0]), .blk_ready(br_o[0]),
    .blk_data(bd_i[0]), .advance(adv_i[0]), .round_valid(rv_o[0]),
    .round_idx(idx_o[0]), .W(w_o[0]), .K(k_o[0]), .init(init_o[0]), .done(done_o[0])
  );

  sha256_msg_schedule #(.NUM_ROUNDS(20)) dut1 (
    .clk(clk), .rst(rst_i[1]), .blk_valid(bv_i[1]), .blk_ready(br_o[1]),
    .blk_data(bd_i[1]), .advance(adv_i[1]), .round_valid(rv_o[1]),
    .round_idx(idx_o[1]), .W(w_o[1]), .K(k_o[1]), .init(init_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          nr [2] = '{64, 20};
  logic [31:0] kexp [64];
  logic [31:0] wtmp [64];
  logic [31:0] wexp [2][64];
  bit          busy [2];
  int          t [2];
  bit          just_rst [2];
  bit          started = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Fractional 32 bits of cbrt(p): floor(cbrt(p * 2^96)) mod 2^32.
  function automatic logic [31:0] kcalc(input int p);
    logic [127:0] tgt, lo, hi, mid;
    tgt = 128'(p) << 96;
    lo  = 128'd0;
    hi  = 128'd1 << 36;
    while (hi - lo > 128'd1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid * mid <= tgt) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  task automatic expand_block(input logic [511:0] b);
    for (int n = 0; n < 16; n++) wtmp[n] = b[32*(15-n) +: 32];
    for (int n = 16; n < 64; n++)
      wtmp[n] = ssig1(wtmp[n-2]) + wtmp[n-7] + ssig0(wtmp[n-15]) + wtmp[n-16];
  endtask

  task automatic load_model(input int i, input logic [511:0] b);
    expand_block(b);
    for (int n = 0; n < 64; n++) wexp[i][n] = wtmp[n];
    busy[i] = 1;
    t[i]    = 0;
  endtask

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s got %h want %h", i, name, act, exp);
    end
  endtask

  // Model advances on the same edges the DUT samples.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      just_rst[i] = 0;
      if (rst_i[i]) begin
        busy[i] = 0; t[i] = 0; just_rst[i] = 1;
      end else if (!busy[i]) begin
        if (bv_i[i]) load_model(i, bd_i[i]);
      end else if (adv_i[i]) begin
        if (t[i] == nr[i] - 1) begin
`ifdef SHA_SCHED_PREFETCH_EN
          if (bv_i[i]) load_model(i, bd_i[i]);
          else busy[i] = 0;
`else
          busy[i] = 0;
`endif
        end else begin
          t[i] = t[i] + 1;
        end
      end
    end
    started = 1;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic exp_rdy;
        exp_rdy = !busy[i];
`ifdef SHA_SCHED_PREFETCH_EN
        if (busy[i] && t[i] == nr[i] - 1 && adv_i[i]) exp_rdy = 1'b1;
`endif
        chk(i, "round_valid", 32'(rv_o[i]), 32'(busy[i]));
        chk(i, "blk_ready", 32'(br_o[i]), 32'(exp_rdy));
        if (busy[i]) begin
          chk(i, "round_idx", 32'(idx_o[i]), 32'(t[i]));
          chk(i, "W", w_o[i], wexp[i][t[i]]);
          chk(i, "K", k_o[i], kexp[t[i]]);
          chk(i, "init", 32'(init_o[i]), 32'(t[i] == 0));
          chk(i, "done", 32'(done_o[i]), 32'(t[i] == nr[i] - 1));
        end else begin
          chk(i, "init_idle", 32'(init_o[i]), 32'd0);
          chk(i, "done_idle", 32'(done_o[i]), 32'd0);
        end
        if (just_rst[i]) begin
          chk(i, "rst_W", w_o[i], 32'd0);
          chk(i, "rst_K", k_o[i], 32'd0);
          chk(i, "rst_idx", 32'(idx_o[i]), 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] capw [64];
  logic [31:0] capk [64];
  int          ninit, ndone;

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int n = 0; n < 16; n++) b[32*n +: 32] = $urandom();
    return b;
  endfunction

  // Called at posedge+1 with instance k idle; presents b for one cycle.
  task automatic drive_block(input int k, input logic [511:0] b, input bit hold,
                             input logic [511:0] b2, input int stall_at, input int stall_len,
                             input int rst_at, input int ncyc, input int exp_valid);
    int nvalid;
    nvalid = 0; ninit = 0; ndone = 0;
    bv_i[k] = 1'b1; bd_i[k] = b; adv_i[k] = 1'b1; rst_i[k] = 1'b0;
    @(posedge clk); #1;
    if (hold) bd_i[k] = b2;
    else bv_i[k] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      adv_i[k] = !(c >= stall_at && c < stall_at + stall_len);
      rst_i[k] = (c == rst_at);
      @(negedge clk);
      if (rv_o[k]) begin
        nvalid++;
        capw[idx_o[k]] = w_o[k];
        capk[idx_o[k]] = k_o[k];
        if (init_o[k]) ninit++;
        if (done_o[k]) ndone++;
      end
      @(posedge clk); #1;
    end
    rst_i[k] = 1'b0; adv_i[k] = 1'b1;
    chk(k, "valid_count", 32'(nvalid), 32'(exp_valid));
    @(negedge clk);
    if (!hold) chk(k, "idle_after", 32'(rv_o[k]), 32'd0);
    @(posedge clk); #1;
    if (hold) begin
      bv_i[k] = 1'b0;
      repeat (80) @(posedge clk);
      #1;
    end
  endtask

  logic [511:0] abc;
  bit           hs [2];

  initial begin
    int cnt;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    cnt = 0;
    for (int p = 2; cnt < 64; p++) begin
      bit isp;
      isp = 1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 0;
      if (isp) begin kexp[cnt] = kcalc(p); cnt++; end
    end
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1'b1; bv_i[i] = 1'b0; bd_i[i] = '0; adv_i[i] = 1'b0;
    end

    // Pin the model against published values.
    expand_block(abc);
    chk(0, "model_W16", wtmp[16], 32'h61626380);
    chk(0, "model_W17", wtmp[17], 32'h000f0000);
    chk(0, "model_K0", kexp[0], 32'h428a2f98);
    chk(0, "model_K63", kexp[63], 32'hc67178f2);

    repeat (2) @(posedge clk);
    #1;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    @(posedge clk); #1;

    // "abc" block, no stalls.
    drive_block(0, abc, 0, '0, -1, 0, -1, 64, 64);
    chk(0, "abc_W0", capw[0], 32'h61626380);
    chk(0, "abc_W15", capw[15], 32'h00000018);
    chk(0, "abc_W16", capw[16], 32'h61626380);
    chk(0, "abc_W17", capw[17], 32'h000f0000);
    chk(0, "abc_K0", capk[0], 32'h428a2f98);
    chk(0, "abc_K63", capk[63], 32'hc67178f2);
    chk(0, "abc_init_cnt", 32'(ninit), 32'd1);
    chk(0, "abc_done_cnt", 32'(ndone), 32'd1);

    // Five-cycle stall at t=20.
    drive_block(0, rand_block(), 0, '0, 20, 5, -1, 69, 69);

    // Reset at t=30, then a fresh "abc" block.
    drive_block(0, rand_block(), 0, '0, -1, 0, 30, 31, 31);
    drive_block(0, abc, 0, '0, -1, 0, -1, 64, 64);
    chk(0, "abc2_W17", capw[17], 32'h000f0000);

    // Second block held valid throughout the first.
    drive_block(0, abc, 1, rand_block(), -1, 0, -1, 64, 64);
    chk(0, "hold_W16", capw[16], 32'h61626380);

    // Reduced-round instance.
    drive_block(1, abc, 0, '0, -1, 0, -1, 20, 20);
    chk(1, "nr20_done_cnt", 32'(ndone), 32'd1);
    chk(1, "nr20_W17", capw[17], 32'h000f0000);

    // Randomized traffic on both instances.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) hs[k] = bv_i[k] && br_o[k] && !rst_i[k];
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!(bv_i[k] && !hs[k])) begin
          bv_i[k] = ($urandom_range(0, 3) == 0);
          bd_i[k] = rand_block();
        end
        adv_i[k] = ($urandom_range(0, 3) != 0);
        rst_i[k] = ($urandom_range(0, 599) == 0);
      end
    end
    for (int k = 0; k < 2; k++) begin rst_i[k] = 1'b0; bv_i[k] = 1'b0; end
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
